// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage register with load data formatting.
//
// Captures one instruction from the MEM stage per cycle. It then drives the
// register-file write port from the held fields. For loads it selects a byte
// or halfword from the raw memory word according to BIG_ENDIAN and extends
// it. It flags misaligned loads and counts retired instructions.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   in_valid      in   MEM-stage instruction present
//   stall         in   hold WB contents, ignore inputs
//   flush         in   invalidate WB (priority over stall)
//   alu_result    in   [31:0] ALU result
//   mem_rdata     in   [31:0] aligned data-memory word
//   link_pc       in   [31:0] return address for JAL/JALR
//   dest_reg      in   [4:0]  destination register
//   reg_write     in   instruction writes a register
//   wb_sel        in   [1:0]  00/11 ALU, 01 load, 10 link
//   load_type     in   [2:0]  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
//   addr_lo       in   [1:0]  low bits of the load address
//   WN            out  [4:0]  register-file write number
//   Input         out  [31:0] register-file write data
//   RegWrite      out  register-file write enable
//   wb_valid      out  WB holds a valid instruction
//   misalign      out  held load is misaligned
//   retire_count  out  [31:0] retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module wb_stage #(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] alu_result,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] link_pc,
   input  logic [4:0]  dest_reg,
   input  logic        reg_write,
   input  logic [1:0]  wb_sel,
   input  logic [2:0]  load_type,
   input  logic [1:0]  addr_lo,
   output logic [4:0]  WN,
   output logic [31:0] Input,
   output logic        RegWrite,
   output logic        wb_valid,
   output logic        misalign,
   output logic [31:0] retire_count
);

   // Held WB fields
   logic        valid_q,  valid_d;
   logic [31:0] alu_q,    alu_d;
   logic [31:0] rdata_q,  rdata_d;
   logic [31:0] link_q,   link_d;
   logic [4:0]  dest_q,   dest_d;
   logic        regw_q,   regw_d;
   logic [1:0]  sel_q,    sel_d;
   logic [2:0]  ltype_q,  ltype_d;
   logic [1:0]  addr_q,   addr_d;
   logic [31:0] retire_q, retire_d;

   // Next-state: flush beats stall; a retire is counted on any advancing
   // edge where the stage currently holds a valid instruction.
   always_comb begin
      valid_d  = valid_q;
      alu_d    = alu_q;
      rdata_d  = rdata_q;
      link_d   = link_q;
      dest_d   = dest_q;
      regw_d   = regw_q;
      sel_d    = sel_q;
      ltype_d  = ltype_q;
      addr_d   = addr_q;
      retire_d = retire_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d  = in_valid;
         alu_d    = alu_result;
         rdata_d  = mem_rdata;
         link_d   = link_pc;
         dest_d   = dest_reg;
         regw_d   = reg_write;
         sel_d    = wb_sel;
         ltype_d  = load_type;
         addr_d   = addr_lo;
         retire_d = retire_q + {31'd0, valid_q};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         alu_q    <= '0;
         rdata_q  <= '0;
         link_q   <= '0;
         dest_q   <= '0;
         regw_q   <= 1'b0;
         sel_q    <= '0;
         ltype_q  <= '0;
         addr_q   <= '0;
         retire_q <= '0;
      end else begin
         valid_q  <= valid_d;
         alu_q    <= alu_d;
         rdata_q  <= rdata_d;
         link_q   <= link_d;
         dest_q   <= dest_d;
         regw_q   <= regw_d;
         sel_q    <= sel_d;
         ltype_q  <= ltype_d;
         addr_q   <= addr_d;
         retire_q <= retire_d;
      end
   end

   // byte_lane[n] / half_lane[n] hold the byte / halfword at address offset n
   // of the word, so endianness is resolved once here.
   logic [7:0]  byte_lane [4];
   logic [15:0] half_lane [2];

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      if (BIG_ENDIAN) begin : g_be
         assign byte_lane[gi] = rdata_q[31-8*gi -: 8];
      end else begin : g_le
         assign byte_lane[gi] = rdata_q[8*gi +: 8];
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_half
      if (BIG_ENDIAN) begin : g_be
         assign half_lane[gi] = rdata_q[31-16*gi -: 16];
      end else begin : g_le
         assign half_lane[gi] = rdata_q[16*gi +: 16];
      end
   end

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic        is_half;
   logic        is_word;

   assign sel_byte = byte_lane[addr_q];
   assign sel_half = half_lane[addr_q[1]];

   // Unlisted load_type encodings behave as LW.
   assign is_half = (ltype_q == 3'b011) || (ltype_q == 3'b100);
   assign is_word = !((ltype_q == 3'b001) || (ltype_q == 3'b010) || is_half);

   always_comb begin
      case (ltype_q)
         3'b001:  load_data = {{24{sel_byte[7]}}, sel_byte};
         3'b010:  load_data = {24'd0, sel_byte};
         3'b011:  load_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_data = {16'd0, sel_half};
         default: load_data = rdata_q;
      endcase
   end

   always_comb begin
      case (sel_q)
         2'b01:   Input = load_data;
         2'b10:   Input = link_q;
         default: Input = alu_q;
      endcase
   end

   assign misalign = valid_q && (sel_q == 2'b01) &&
                     ((is_half && addr_q[0]) || (is_word && (addr_q != 2'b00)));

   assign RegWrite     = valid_q && regw_q && (dest_q != 5'd0) && !misalign;
   assign WN           = dest_q;
   assign wb_valid     = valid_q;
   assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, stall, flush, reg_write;
   logic [31:0] alu_result, mem_rdata, link_pc;
   logic [4:0]  dest_reg;
   logic [1:0]  wb_sel, addr_lo;
   logic [2:0]  load_type;

   logic [4:0]  wn_b, wn_l;
   logic [31:0] inp_b, inp_l, rc_b, rc_l;
   logic        rw_b, rw_l, vld_b, vld_l, mis_b, mis_l;

   wb_stage #(.BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu_result(alu_result), .mem_rdata(mem_rdata), .link_pc(link_pc),
      .dest_reg(dest_reg), .reg_write(reg_write), .wb_sel(wb_sel),
      .load_type(load_type), .addr_lo(addr_lo),
      .WN(wn_b), .Input(inp_b), .RegWrite(rw_b), .wb_valid(vld_b),
      .misalign(mis_b), .retire_count(rc_b));

   wb_stage #(.BIG_ENDIAN(1'b0)) dut_le (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu_result(alu_result), .mem_rdata(mem_rdata), .link_pc(link_pc),
      .dest_reg(dest_reg), .reg_write(reg_write), .wb_sel(wb_sel),
      .load_type(load_type), .addr_lo(addr_lo),
      .WN(wn_l), .Input(inp_l), .RegWrite(rw_l), .wb_valid(vld_l),
      .misalign(mis_l), .retire_count(rc_l));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: the architectural content of the WB stage.
   bit          m_valid, m_known, m_regw;
   logic [31:0] m_alu, m_rdata, m_link, m_retire;
   logic [4:0]  m_dest;
   logic [1:0]  m_sel, m_addr;
   logic [2:0]  m_lt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d observed=%08h expected=%08h", tag, cyc, obs, exp);
      end
   endtask

   // Write data from the architectural rules: address offset k names a byte,
   // big-endian puts offset 0 in the most significant byte.
   function automatic logic [31:0] ref_data(input bit be);
      int unsigned lane, v;
      if (m_sel == 2'd2) return m_link;
      if (m_sel != 2'd1) return m_alu;
      case (m_lt)
         3'd1, 3'd2: begin
            lane = be ? 3 - m_addr : m_addr;
            v = (m_rdata >> (8 * lane)) & 32'hFF;
            if (m_lt == 3'd1 && v >= 128) v = v + 32'hFFFFFF00;
            return v;
         end
         3'd3, 3'd4: begin
            lane = be ? 1 - (m_addr / 2) : (m_addr / 2);
            v = (m_rdata >> (16 * lane)) & 32'hFFFF;
            if (m_lt == 3'd3 && v >= 32768) v = v + 32'hFFFF0000;
            return v;
         end
         default: return m_rdata;
      endcase
   endfunction

   function automatic bit ref_mis();
      bit half_ld, word_ld;
      half_ld = (m_lt == 3'd3) || (m_lt == 3'd4);
      word_ld = (m_lt == 3'd0) || (m_lt > 3'd4);
      return m_valid && (m_sel == 2'd1) &&
             ((half_ld && (m_addr % 2 == 1)) || (word_ld && m_addr != 2'd0));
   endfunction

   task automatic drv(input bit v, input logic [1:0] sel, input logic [2:0] lt,
                      input logic [1:0] a, input logic [31:0] alu, input logic [31:0] rd,
                      input logic [31:0] lk, input logic [4:0] d, input bit rw);
      in_valid = v; wb_sel = sel; load_type = lt; addr_lo = a; alu_result = alu;
      mem_rdata = rd; link_pc = lk; dest_reg = d; reg_write = rw;
   endtask

   task automatic step();
      bit mis, rw;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 0; m_known = 1; m_alu = 0; m_rdata = 0; m_link = 0;
         m_dest = 0; m_regw = 0; m_sel = 0; m_lt = 0; m_addr = 0; m_retire = 0;
      end else if (flush) begin
         m_valid = 0; m_known = 0;
      end else if (!stall) begin
         if (m_valid) m_retire = m_retire + 1;
         m_valid = in_valid; m_known = 1; m_alu = alu_result; m_rdata = mem_rdata;
         m_link = link_pc; m_dest = dest_reg; m_regw = reg_write; m_sel = wb_sel;
         m_lt = load_type; m_addr = addr_lo;
      end
      #1;
      cyc++;
      mis = ref_mis();
      rw  = m_valid && m_regw && (m_dest != 0) && !mis;
      check("wb_valid_be", {31'd0, vld_b}, {31'd0, m_valid});
      check("wb_valid_le", {31'd0, vld_l}, {31'd0, m_valid});
      check("misalign_be", {31'd0, mis_b}, {31'd0, mis});
      check("misalign_le", {31'd0, mis_l}, {31'd0, mis});
      check("regwrite_be", {31'd0, rw_b}, {31'd0, rw});
      check("regwrite_le", {31'd0, rw_l}, {31'd0, rw});
      check("retire_be", rc_b, m_retire);
      check("retire_le", rc_l, m_retire);
      if (m_known) begin
         check("wn_be", {27'd0, wn_b}, {27'd0, m_dest});
         check("wn_le", {27'd0, wn_l}, {27'd0, m_dest});
         check("input_be", inp_b, ref_data(1'b1));
         check("input_le", inp_l, ref_data(1'b0));
      end
      $display("cyc %0d rst_n=%0b stall=%0b flush=%0b vld=%0b WN=%0d Input=%08h/%08h RegWrite=%0b mis=%0b retire=%08h",
               cyc, rst_n, stall, flush, vld_b, wn_b, inp_b, inp_l, rw_b, mis_b, rc_b);
   endtask

   initial begin
      rst_n = 0; stall = 0; flush = 0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_valid = 0; m_known = 0; m_regw = 0; m_retire = 0;
      m_alu = 0; m_rdata = 0; m_link = 0; m_dest = 0; m_sel = 0; m_lt = 0; m_addr = 0;
      @(negedge clk);
      step(); step();
      check("reset_input", inp_b, 32'd0);
      check("reset_retire", rc_b, 32'd0);
      rst_n = 1;

      // ALU op, then idle so the retire is counted.
      drv(1, 2'd0, 3'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd5, 1);
      step();
      check("alu_wn", {27'd0, wn_b}, 32'd5);
      check("alu_input", inp_b, 32'h12345678);
      check("alu_regwrite", {31'd0, rw_b}, 32'd1);
      drv(0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
      step();
      check("alu_retire", rc_b, 32'd1);

      // Load formatting vectors.
      drv(1, 2'd1, 3'd1, 2'd0, 32'h0, 32'h80F17F02, 32'h0, 5'd7, 1); step();
      check("lb_a0", inp_b, 32'hFFFFFF80);
      drv(1, 2'd1, 3'd2, 2'd1, 32'h0, 32'h80F17F02, 32'h0, 5'd7, 1); step();
      check("lbu_a1", inp_b, 32'h000000F1);
      drv(1, 2'd1, 3'd3, 2'd2, 32'h0, 32'h80F17F02, 32'h0, 5'd7, 1); step();
      check("lh_a2", inp_b, 32'h00007F02);
      drv(1, 2'd1, 3'd4, 2'd0, 32'h0, 32'h80F17F02, 32'h0, 5'd7, 1); step();
      check("lhu_a0", inp_b, 32'h000080F1);

      // Misaligned loads, x0 write, JAL link.
      drv(1, 2'd1, 3'd0, 2'd2, 32'h0, 32'h80F17F02, 32'h0, 5'd9, 1); step();
      check("lw_misalign", {31'd0, mis_b}, 32'd1);
      drv(1, 2'd1, 3'd3, 2'd3, 32'h0, 32'h80F17F02, 32'h0, 5'd9, 1); step();
      check("lh_misalign", {31'd0, mis_b}, 32'd1);
      drv(1, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 1); step();
      check("x0_regwrite", {31'd0, rw_b}, 32'd0);
      drv(1, 2'd2, 3'd5, 2'd3, 32'h0, 32'h0, 32'h00400008, 5'd31, 1); step();
      check("jal_input", inp_b, 32'h00400008);
      check("jal_wn", {27'd0, wn_b}, 32'd31);

      // Stall three cycles with changing inputs, then flush+stall, reset in stall.
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         drv(1, 2'd0, 3'd0, 2'd0, $urandom, $urandom, $urandom, 5'($urandom), 1);
         step();
      end
      flush = 1; step(); flush = 0;
      check("flush_stall_valid", {31'd0, vld_b}, 32'd0);
      drv(1, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0, 5'd3, 1); stall = 0; step();
      stall = 1; step(); rst_n = 0; step(); rst_n = 1; stall = 0;
      check("rst_in_stall_retire", rc_b, 32'd0);

      // Counter wrap: preload both counters to all-ones.
      drv(1, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0, 5'd1, 1); step();
      force dut_be.retire_q = 32'hFFFFFFFF;
      force dut_le.retire_q = 32'hFFFFFFFF;
      #1;
      release dut_be.retire_q;
      release dut_le.retire_q;
      m_retire = 32'hFFFFFFFF;
      step();
      check("retire_wrap", rc_b, 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         drv($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom,
             ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
